// File: rtl/mult_norm_seq.sv
// Sequential mantissa multiply + normalization stage of the binary32 multiplier.
// Radix-2 shift-add over 24 multiplier bits, then a one-cycle normalize step.
// Output feeds the rounding stage: sign, wrapped exponent, 23-bit fraction,
// guard/sticky and operand-class flags.
module mult_norm_seq #(
  parameter int BIAS  = 127,
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] norm_exponent,
  output logic [22:0]      norm_mantissa,
  output logic             guard_bit,
  output logic             sticky_bit,
  output logic             zero_f,
  output logic             inf_f,
  output logic             nan_f
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_reg;
  logic [4:0]       cnt_reg;
  logic [23:0]      sa_reg;
  logic [23:0]      sb_reg;
  logic [47:0]      p_reg;
  logic [EXP_W-1:0] exp_sum_reg;
  logic             sign_reg;
  logic             zero_reg;
  logic             inf_reg;
  logic             nan_reg;
  logic [EXP_W-1:0] exp_out_reg;
  logic [22:0]      man_reg;
  logic             guard_reg;
  logic             sticky_reg;

  // Raw operand fields
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic nan_in, inf_in, zero_in;
  logic [EXP_W-1:0] exp_sum_in;
  logic [47:0]      addend;

  // Operand classification; zero class is exponent == 0 (denormals included)
  always_comb begin
    a_nan   = (&ea) & (|fa);
    b_nan   = (&eb) & (|fb);
    a_inf   = (&ea) & ~(|fa);
    b_inf   = (&eb) & ~(|fb);
    a_zero  = ~(|ea);
    b_zero  = ~(|eb);
    nan_in  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    inf_in  = (a_inf | b_inf) & ~nan_in;
    zero_in = (a_zero | b_zero) & ~nan_in;
    // Biased sum wraps at EXP_W so underflow shows up as a negative value
    exp_sum_in = EXP_W'(ea) + EXP_W'(eb) - EXP_W'(BIAS);
  end

  // Partial product for the current multiplier bit (LSB first)
  always_comb begin
    addend = '0;
    if (sb_reg[cnt_reg])
      addend = {24'd0, sa_reg} << cnt_reg;
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      sa_reg      <= '0;
      sb_reg      <= '0;
      p_reg       <= '0;
      exp_sum_reg <= '0;
      sign_reg    <= 1'b0;
      zero_reg    <= 1'b0;
      inf_reg     <= 1'b0;
      nan_reg     <= 1'b0;
      exp_out_reg <= '0;
      man_reg     <= '0;
      guard_reg   <= 1'b0;
      sticky_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            state_reg   <= S_MUL;
            cnt_reg     <= '0;
            p_reg       <= '0;
            sa_reg      <= {~a_zero, fa};
            sb_reg      <= {~b_zero, fb};
            exp_sum_reg <= exp_sum_in;
            sign_reg    <= a[31] ^ b[31];
            zero_reg    <= zero_in;
            inf_reg     <= inf_in;
            nan_reg     <= nan_in;
          end
        end
        S_MUL: begin
          p_reg   <= p_reg + addend;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd23) begin
            state_reg <= S_NORM;
            cnt_reg   <= '0;
          end
        end
        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4): at most one shift
          if (p_reg[47]) begin
            man_reg     <= p_reg[46:24];
            guard_reg   <= p_reg[23];
            sticky_reg  <= |p_reg[22:0];
            exp_out_reg <= exp_sum_reg + EXP_W'(1);
          end else begin
            man_reg     <= p_reg[45:23];
            guard_reg   <= p_reg[22];
            sticky_reg  <= |p_reg[21:0];
            exp_out_reg <= exp_sum_reg;
          end
          state_reg <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_reg == S_IDLE);
  assign out_valid     = (state_reg == S_DONE);
  assign sign          = sign_reg;
  assign norm_exponent = exp_out_reg;
  assign norm_mantissa = man_reg;
  assign guard_bit     = guard_reg;
  assign sticky_bit    = sticky_reg;
  assign zero_f        = zero_reg;
  assign inf_f         = inf_reg;
  assign nan_f         = nan_reg;

endmodule
